// File: rtl/core_decode_stage.sv
// LETC decode stage: decodes fetched instructions and hands them to execute through a
// two-entry (main + skid) buffer so f_ready comes straight from a flop at full throughput.
module core_decode_stage #(
  parameter bit FLAG_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        f_valid,
  output logic        f_ready,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_instr,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [31:0] d_pc,
  output logic [4:0]  d_opcode,
  output logic [2:0]  d_format,
  output logic [1:0]  d_rd_src,
  output logic        d_rd_we,
  output logic [4:0]  d_rd_idx,
  output logic [4:0]  d_rs1_idx,
  output logic [4:0]  d_rs2_idx,
  output logic [2:0]  d_funct3,
  output logic [11:0] d_csr_idx,
  output logic [31:0] d_immediate,
  output logic        d_illegal
);

  typedef enum logic [4:0] {
    OPC_LOAD = 5'b00000, OPC_MISC_MEM = 5'b00011, OPC_OP_IMM = 5'b00100,
    OPC_AUIPC = 5'b00101, OPC_STORE = 5'b01000, OPC_OP = 5'b01100,
    OPC_LUI = 5'b01101, OPC_BRANCH = 5'b11000, OPC_JALR = 5'b11001,
    OPC_JAL = 5'b11011, OPC_SYSTEM = 5'b11100
  } opcode_e;

  typedef enum logic [2:0] {
    FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
    FMT_U = 3'd4, FMT_J = 3'd5, FMT_UIMM = 3'd6, FMT_UNKNOWN = 3'd7
  } instr_format_e;

  typedef enum logic [1:0] {
    RD_FROM_ALU_RESULT = 2'd0, RD_FROM_MEM_LOAD = 2'd1,
    RD_FROM_NEXT_SEQ_PC = 2'd2, RD_FROM_CSR = 2'd3
  } rd_src_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  opcode;
    logic [2:0]  format;
    logic [1:0]  rd_src;
    logic        rd_we;
    logic [4:0]  rd_idx;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [2:0]  funct3;
    logic [11:0] csr_idx;
    logic [31:0] immediate;
    logic        illegal;
  } dec_t;

  dec_t          dec;
  instr_format_e fmt;
  rd_src_e       src;
  logic          we;
  logic          ill;
  logic [31:0]   ins;

  assign ins = f_instr;

  always_comb begin
    fmt = FMT_UNKNOWN;
    src = RD_FROM_ALU_RESULT;
    we  = 1'b0;
    ill = 1'b0;
    case (opcode_e'(ins[6:2]))
      OPC_LOAD:     begin fmt = FMT_I; src = RD_FROM_MEM_LOAD;    we = 1'b1; end
      OPC_MISC_MEM: begin fmt = FMT_I; end
      OPC_OP_IMM:   begin fmt = FMT_I; we = 1'b1; end
      OPC_AUIPC,
      OPC_LUI:      begin fmt = FMT_U; we = 1'b1; end
      OPC_STORE:    begin fmt = FMT_S; end
      OPC_OP:       begin fmt = FMT_R; we = 1'b1; end
      OPC_BRANCH:   begin fmt = FMT_B; end
      OPC_JALR:     begin fmt = FMT_I; src = RD_FROM_NEXT_SEQ_PC; we = 1'b1; end
      OPC_JAL:      begin fmt = FMT_J; src = RD_FROM_NEXT_SEQ_PC; we = 1'b1; end
      OPC_SYSTEM: begin
        if (ins[14:12] == 3'b000) begin
          fmt = FMT_I;
        end else begin
          fmt = ins[14] ? FMT_UIMM : FMT_I;
          src = RD_FROM_CSR;
          we  = 1'b1;
          ill = (ins[14:12] == 3'b100);
        end
      end
      default: ill = 1'b1;
    endcase
    // Non-32-bit encodings (compressed space) are not supported at all.
    if (ins[1:0] != 2'b11) begin
      fmt = FMT_UNKNOWN;
      src = RD_FROM_ALU_RESULT;
      we  = 1'b0;
      ill = 1'b1;
    end
    if (ins[11:7] == 5'd0) we = 1'b0;
    if (!FLAG_ILLEGAL) ill = 1'b0;

    dec           = '0;
    dec.pc        = f_pc;
    dec.opcode    = ins[6:2];
    dec.format    = fmt;
    dec.rd_src    = src;
    dec.rd_we     = we;
    dec.rd_idx    = ins[11:7];
    dec.rs1_idx   = ins[19:15];
    dec.rs2_idx   = ins[24:20];
    dec.funct3    = ins[14:12];
    dec.csr_idx   = ins[31:20];
    dec.illegal   = ill;
    case (fmt)
      FMT_I:    dec.immediate = {{20{ins[31]}}, ins[31:20]};
      FMT_S:    dec.immediate = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:    dec.immediate = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:    dec.immediate = {ins[31:12], 12'b0};
      FMT_J:    dec.immediate = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      FMT_UIMM: dec.immediate = {27'b0, ins[19:15]};
      default:  dec.immediate = 32'd0;
    endcase
  end

  dec_t main_q, main_d, skid_q, skid_d;
  logic main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic in_fire, out_fire;

  assign f_ready  = !skid_valid_q;
  assign in_fire  = f_valid && f_ready;
  assign out_fire = main_valid_q && d_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q && out_fire) begin
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end else if (in_fire && (!main_valid_q || out_fire)) begin
      main_d       = dec;
      main_valid_d = 1'b1;
    end else if (in_fire) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end else if (out_fire) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign d_valid     = main_valid_q;
  assign d_pc        = main_q.pc;
  assign d_opcode    = main_q.opcode;
  assign d_format    = main_q.format;
  assign d_rd_src    = main_q.rd_src;
  assign d_rd_we     = main_q.rd_we;
  assign d_rd_idx    = main_q.rd_idx;
  assign d_rs1_idx   = main_q.rs1_idx;
  assign d_rs2_idx   = main_q.rs2_idx;
  assign d_funct3    = main_q.funct3;
  assign d_csr_idx   = main_q.csr_idx;
  assign d_immediate = main_q.immediate;
  assign d_illegal   = main_q.illegal;

endmodule
